// File: rtl/pl_stage_exe_md.sv
`default_nettype none
// ============================================================================
// Module   : pl_stage_exe_md
// Purpose  : Pipeline EX stage. Holds the combinational ALU and a sequential
//            radix-2 multiply/divide unit for the M extension, and produces
//            the EX result mux and the EX trap report.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, clrn              clock, synchronous active-low reset
//   ea, eb                 operands (rs1, rs2/immediate)
//   epc4                   link value, selected by ecall
//   ealuc                  ALU control (see ALU_* encodings below)
//   ecall                  select epc4 as the result
//   csr_is_ex/csr_rdata_ex select CSR read data as the result
//   ex_v, md_req, efunc3   valid EX instruction, M-op request, M-op code
//   flush                  kill the EX instruction / abort an M op
//   eal, zout              EX result, ALU zero flag
//   md_busy                stall request while an M op is in flight
//   trap_ex_*              trap report (3 = ALU overflow, 4 = divide by zero)
// ALU encoding
//   0000 ADD  1000 SUB  0001 SLL  0010 SLT  0011 SLTU  0100 XOR
//   0101 SRL  1101 SRA  0110 OR   0111 AND  others: pass eb (LUI)
// ============================================================================
module pl_stage_exe_md #(
  parameter int XLEN      = 32,
  parameter bit TRAP_DIV0 = 1'b0
) (
  input  logic            clk,
  input  logic            clrn,
  input  logic [XLEN-1:0] ea,
  input  logic [XLEN-1:0] eb,
  input  logic [XLEN-1:0] epc4,
  input  logic [3:0]      ealuc,
  input  logic            ecall,
  input  logic            csr_is_ex,
  input  logic [XLEN-1:0] csr_rdata_ex,
  input  logic            ex_v,
  input  logic            md_req,
  input  logic [2:0]      efunc3,
  input  logic            flush,
  output logic [XLEN-1:0] eal,
  output logic            zout,
  output logic            md_busy,
  output logic            trap_ex_v,
  output logic            trap_ex_is_intr,
  output logic [3:0]      trap_ex_cause
);

  localparam int            CW         = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST   = CW'(XLEN - 1);
  localparam logic [3:0]    ALU_ADD    = 4'b0000;
  localparam logic [3:0]    ALU_SUB    = 4'b1000;
  localparam logic [3:0]    ALU_SLL    = 4'b0001;
  localparam logic [3:0]    ALU_SLT    = 4'b0010;
  localparam logic [3:0]    ALU_SLTU   = 4'b0011;
  localparam logic [3:0]    ALU_XOR    = 4'b0100;
  localparam logic [3:0]    ALU_SRL    = 4'b0101;
  localparam logic [3:0]    ALU_SRA    = 4'b1101;
  localparam logic [3:0]    ALU_OR     = 4'b0110;
  localparam logic [3:0]    ALU_AND    = 4'b0111;
  localparam logic [3:0]    CAUSE_OVF  = 4'd3;
  localparam logic [3:0]    CAUSE_DIV0 = 4'd4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic            div0_q, div0_d;
  logic [XLEN-1:0] a_q, a_d;      // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d;    // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;    // multiplier / dividend shifting into quotient
  logic [XLEN-1:0] res_q, res_d;

  // ---------------------------------------------------------------- ALU
  logic [XLEN-1:0] sum_w, diff_w, alu_r;
  logic [CW-1:0]   shamt_w;
  logic            alu_ovf;

  always_comb begin
    sum_w   = ea + eb;
    diff_w  = ea - eb;
    shamt_w = eb[CW-1:0];
    alu_ovf = 1'b0;
    case (ealuc)
      ALU_ADD: begin
        alu_r   = sum_w;
        alu_ovf = (ea[XLEN-1] == eb[XLEN-1]) && (sum_w[XLEN-1] != ea[XLEN-1]);
      end
      ALU_SUB: begin
        alu_r   = diff_w;
        alu_ovf = (ea[XLEN-1] != eb[XLEN-1]) && (diff_w[XLEN-1] != ea[XLEN-1]);
      end
      ALU_SLL:  alu_r = ea << shamt_w;
      ALU_SLT:  alu_r = {{(XLEN-1){1'b0}}, ($signed(ea) < $signed(eb))};
      ALU_SLTU: alu_r = {{(XLEN-1){1'b0}}, (ea < eb)};
      ALU_XOR:  alu_r = ea ^ eb;
      ALU_SRL:  alu_r = ea >> shamt_w;
      ALU_SRA:  alu_r = $unsigned($signed(ea) >>> shamt_w);
      ALU_OR:   alu_r = ea | eb;
      ALU_AND:  alu_r = ea & eb;
      default:  alu_r = eb;
    endcase
  end

  assign zout = (alu_r == '0);

  // ------------------------------------------------ M-unit operand prep
  logic            start_w, div0_w, a_sgn_w, b_sgn_w, a_neg_w, b_neg_w, neg_w;
  logic [XLEN-1:0] a_mag_w, b_mag_w;

  assign start_w = (state_q == S_IDLE) && ex_v && md_req && !flush;
  assign div0_w  = efunc3[2] && (eb == '0);
  // MULHU, DIVU, REMU treat rs1 as unsigned; MULHSU additionally rs2
  assign a_sgn_w = !(efunc3 == 3'b011 || efunc3 == 3'b101 || efunc3 == 3'b111);
  assign b_sgn_w = a_sgn_w && (efunc3 != 3'b010);
  assign a_neg_w = a_sgn_w && ea[XLEN-1];
  assign b_neg_w = b_sgn_w && eb[XLEN-1];
  assign a_mag_w = a_neg_w ? -ea : ea;
  assign b_mag_w = b_neg_w ? -eb : eb;
  // Remainder follows the dividend; product and quotient follow both signs
  assign neg_w   = (efunc3 == 3'b110) ? a_neg_w : (a_neg_w ^ b_neg_w);

  // ------------------------------------------- one radix-2 iteration
  logic [XLEN:0]     madd_w, dsh_w, dsub_w;
  logic [XLEN-1:0]   step_hi_w, step_lo_w, dval_w, fin_w;
  logic [2*XLEN-1:0] prod_w;

  always_comb begin
    // Multiply: add multiplicand when multiplier LSB is set, shift pair right
    madd_w = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    // Divide: restoring step; MSB of the difference is the borrow
    dsh_w  = {hi_q, lo_q[XLEN-1]};
    dsub_w = dsh_w - {1'b0, a_q};
    if (op_q[2]) begin
      if (!dsub_w[XLEN]) begin
        step_hi_w = dsub_w[XLEN-1:0];
        step_lo_w = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        step_hi_w = dsh_w[XLEN-1:0];
        step_lo_w = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      step_hi_w = madd_w[XLEN:1];
      step_lo_w = {madd_w[0], lo_q[XLEN-1:1]};
    end
    prod_w = neg_q ? -{step_hi_w, step_lo_w} : {step_hi_w, step_lo_w};
    dval_w = op_q[1] ? step_hi_w : step_lo_w;
    dval_w = neg_q ? -dval_w : dval_w;
    if (op_q[2])
      fin_w = dval_w;
    else if (op_q[1:0] == 2'b00)
      fin_w = prod_w[XLEN-1:0];
    else
      fin_w = prod_w[2*XLEN-1:XLEN];
  end

  // ------------------------------------------------- FSM next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (start_w) begin
          op_d   = efunc3;
          neg_d  = neg_w;
          div0_d = div0_w;
          cnt_d  = '0;
          hi_d   = '0;
          if (efunc3[2]) begin
            a_d  = b_mag_w;
            lo_d = a_mag_w;
          end else begin
            a_d  = a_mag_w;
            lo_d = b_mag_w;
          end
          if (div0_w) begin
            // Quotient all ones, remainder is the raw dividend
            res_d   = efunc3[1] ? ea : '1;
            state_d = S_DONE;
          end else begin
            res_d   = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        hi_d  = step_hi_w;
        lo_d  = step_lo_w;
        if (cnt_q == CNT_LAST) begin
          res_d   = fin_w;
          state_d = S_DONE;
        end
        if (flush) state_d = S_IDLE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  // ---------------------------------------------------------- outputs
  logic m_out_w, ovf_trap_w, div0_trap_w;

  always_comb begin
    // A flushed DONE cycle delivers neither the result nor the trap
    m_out_w     = (state_q == S_DONE) && !flush;
    ovf_trap_w  = ex_v && alu_ovf && !md_req && !flush;
    div0_trap_w = TRAP_DIV0 && m_out_w && div0_q;
    md_busy     = start_w || (state_q == S_RUN);
    if (m_out_w)        eal = res_q;
    else if (ecall)     eal = epc4;
    else if (csr_is_ex) eal = csr_rdata_ex;
    else                eal = alu_r;
    trap_ex_v       = ovf_trap_w || div0_trap_w;
    trap_ex_is_intr = 1'b0;
    if (div0_trap_w)     trap_ex_cause = CAUSE_DIV0;
    else if (ovf_trap_w) trap_ex_cause = CAUSE_OVF;
    else                 trap_ex_cause = 4'd0;
  end

endmodule
`default_nettype wire

// File: tb/tb_pl_stage_exe_md.sv
`default_nettype none
// ============================================================================
// Module   : tb_pl_stage_exe_md
// Purpose  : Self-checking bench for pl_stage_exe_md. Three instances: 32-bit
//            with the divide-by-zero trap, 32-bit without it, and 16-bit.
//            Expected values come from an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pl_stage_exe_md;

  localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b1000, A_AND = 4'b0111;
  localparam logic [3:0] A_OR = 4'b0110, A_XOR = 4'b0100, A_SLT = 4'b0010, A_SLTU = 4'b0011;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 32-bit stimulus (shared by both 32-bit instances)
  logic        clrn, ecall, csr_is, ex_v, md_req, flush;
  logic [31:0] ea, eb, epc4, csrd;
  logic [3:0]  ealuc;
  logic [2:0]  f3;
  logic [31:0] eal_a, eal_b;
  logic        z_a, z_b, busy_a, busy_b, trap_a, trap_b, intr_a, intr_b;
  logic [3:0]  cause_a, cause_b;
  // 16-bit stimulus
  logic        ecall16, csr16, exv16, mdr16, flush16;
  logic [15:0] ea16, eb16, epc16, csrd16, eal16;
  logic [3:0]  ealuc16, cause16;
  logic [2:0]  f3_16;
  logic        z16, busy16, trap16, intr16;

  pl_stage_exe_md #(.XLEN(32), .TRAP_DIV0(1'b1)) dut_a (
    .clk(clk), .clrn(clrn), .ea(ea), .eb(eb), .epc4(epc4), .ealuc(ealuc),
    .ecall(ecall), .csr_is_ex(csr_is), .csr_rdata_ex(csrd), .ex_v(ex_v),
    .md_req(md_req), .efunc3(f3), .flush(flush), .eal(eal_a), .zout(z_a),
    .md_busy(busy_a), .trap_ex_v(trap_a), .trap_ex_is_intr(intr_a), .trap_ex_cause(cause_a));

  pl_stage_exe_md #(.XLEN(32), .TRAP_DIV0(1'b0)) dut_b (
    .clk(clk), .clrn(clrn), .ea(ea), .eb(eb), .epc4(epc4), .ealuc(ealuc),
    .ecall(ecall), .csr_is_ex(csr_is), .csr_rdata_ex(csrd), .ex_v(ex_v),
    .md_req(md_req), .efunc3(f3), .flush(flush), .eal(eal_b), .zout(z_b),
    .md_busy(busy_b), .trap_ex_v(trap_b), .trap_ex_is_intr(intr_b), .trap_ex_cause(cause_b));

  pl_stage_exe_md #(.XLEN(16), .TRAP_DIV0(1'b0)) dut_16 (
    .clk(clk), .clrn(clrn), .ea(ea16), .eb(eb16), .epc4(epc16), .ealuc(ealuc16),
    .ecall(ecall16), .csr_is_ex(csr16), .csr_rdata_ex(csrd16), .ex_v(exv16),
    .md_req(mdr16), .efunc3(f3_16), .flush(flush16), .eal(eal16), .zout(z16),
    .md_busy(busy16), .trap_ex_v(trap16), .trap_ex_is_intr(intr16), .trap_ex_cause(cause16));

  // ------------------------------------------------ reference models
  function automatic logic [63:0] ref_m(input int n, input logic [2:0] op,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, ua, ub, up;
    longint      sa, sb, sp, smin;
    mask = (64'd1 << n) - 64'd1;
    ua   = a & mask;
    ub   = b & mask;
    sa   = $signed(ua << (64 - n)) >>> (64 - n);
    sb   = $signed(ub << (64 - n)) >>> (64 - n);
    smin = -(longint'(1) << (n - 1));
    case (op)
      3'b000: begin sp = sa * sb; ref_m = sp & mask; end
      3'b001: begin sp = sa * sb; sp = sp >>> n; ref_m = sp & mask; end
      3'b010: begin sp = sa * longint'(ub); sp = sp >>> n; ref_m = sp & mask; end
      3'b011: begin up = ua * ub; up = up >> n; ref_m = up & mask; end
      3'b100: begin
        if (ub == 0) ref_m = mask;
        else if (sa == smin && sb == -1) ref_m = ua;
        else begin sp = sa / sb; ref_m = sp & mask; end
      end
      3'b101: ref_m = (ub == 0) ? mask : (ua / ub);
      3'b110: begin
        if (ub == 0) ref_m = ua;
        else if (sa == smin && sb == -1) ref_m = 64'd0;
        else begin sp = sa % sb; ref_m = sp & mask; end
      end
      default: ref_m = (ub == 0) ? ua : (ua % ub);
    endcase
  endfunction

  function automatic void alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit ov);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    case (c)
      A_ADD:  begin s = sa + sb; r = s[31:0]; ov = (s > MAXS) || (s < MINS); end
      A_SUB:  begin s = sa - sb; r = s[31:0]; ov = (s > MAXS) || (s < MINS); end
      A_AND:  r = a & b;
      A_OR:   r = a | b;
      A_XOR:  r = a ^ b;
      A_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      default: r = (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: pick32 = 32'd0;
      1: pick32 = 32'hFFFF_FFFF;
      2: pick32 = 32'h8000_0000;
      3: pick32 = $urandom_range(0, 20);
      default: pick32 = $urandom;
    endcase
  endfunction

  // ------------------------------------------------ drivers (no checks)
  task automatic idle_inputs();
    ecall = 0; csr_is = 0; ex_v = 0; md_req = 0; flush = 0; f3 = 0;
    ea = 0; eb = 0; epc4 = 0; csrd = 0; ealuc = A_ADD;
    ecall16 = 0; csr16 = 0; exv16 = 0; mdr16 = 0; flush16 = 0; f3_16 = 0;
    ea16 = 0; eb16 = 0; epc16 = 0; csrd16 = 0; ealuc16 = A_ADD;
  endtask

  // Issue one M op on the 32-bit pair; report the DONE-cycle view and stall length
  task automatic do_mop32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] ra, output logic [31:0] rb, output int nbusy,
                          output logic ta, output logic tb, output logic [3:0] ca, output bit tmo);
    @(posedge clk); #1;
    f3 = op; ea = a; eb = b; ealuc = A_ADD; ex_v = 1; md_req = 1;
    nbusy = 0; tmo = 1; ra = 0; rb = 0; ta = 0; tb = 0; ca = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy_a) nbusy++;
      else begin
        ra = eal_a; rb = eal_b; ta = trap_a; tb = trap_b; ca = cause_a; tmo = 0;
        break;
      end
    end
    @(posedge clk); #1;
    ex_v = 0; md_req = 0;
  endtask

  task automatic do_mop16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output int nbusy, output bit tmo);
    @(posedge clk); #1;
    f3_16 = op; ea16 = a; eb16 = b; exv16 = 1; mdr16 = 1;
    nbusy = 0; tmo = 1; r = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy16) nbusy++;
      else begin r = eal16; tmo = 0; break; end
    end
    @(posedge clk); #1;
    exv16 = 0; mdr16 = 0;
  endtask

  // ------------------------------------------------ tests
  task automatic test_reset();
    idle_inputs();
    clrn = 0; ea = 32'd5; eb = 32'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
    total++; if (trap_a !== 1'b0) begin bad++; $display("FAIL reset_trap got=%b exp=0", trap_a); end
    total++; if (eal_a !== 32'd8) begin bad++; $display("FAIL reset_eal got=%h exp=8", eal_a); end
    total++; if (intr_a !== 1'b0) begin bad++; $display("FAIL reset_intr got=%b exp=0", intr_a); end
    @(posedge clk); #1; clrn = 1;
  endtask

  task automatic test_alu();
    logic [31:0] er;
    bit          ov;
    logic [3:0]  ops [7] = '{A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLT, A_SLTU};
    @(posedge clk); #1;
    ealuc = A_ADD; ea = 32'h7FFF_FFFF; eb = 32'd1; ex_v = 1;
    @(negedge clk);
    total++; if (trap_a !== 1'b1 || cause_a !== 4'd3)
      begin bad++; $display("FAIL ovf_trap got=%b/%0d exp=1/3", trap_a, cause_a); end
    total++; if (eal_a !== 32'h8000_0000) begin bad++; $display("FAIL ovf_eal got=%h exp=80000000", eal_a); end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      ealuc = ops[$urandom_range(0, 6)];
      ea = pick32(); eb = ($urandom_range(0, 4) == 0) ? ea : pick32();
      ex_v = $urandom_range(0, 1);
      alu_ref(ealuc, ea, eb, er, ov);
      @(negedge clk);
      total++; if (eal_a !== er) begin bad++; $display("FAIL alu_eal op=%b a=%h b=%h got=%h exp=%h", ealuc, ea, eb, eal_a, er); end
      total++; if (z_a !== (er == 0)) begin bad++; $display("FAIL alu_zout got=%b exp=%b", z_a, er == 0); end
      total++; if (trap_a !== (ov && ex_v)) begin bad++; $display("FAIL alu_trap got=%b exp=%b", trap_a, ov && ex_v); end
    end
    @(posedge clk); #1; ex_v = 0;
  endtask

  task automatic test_md_directed();
    logic [31:0] ra, rb;
    int          nb;
    logic        ta, tb;
    logic [3:0]  ca;
    bit          tmo;
    do_mop32(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ra, rb, nb, ta, tb, ca, tmo);
    total++; if (tmo || nb != 33) begin bad++; $display("FAIL mulh_latency got=%0d exp=33", nb); end
    total++; if (ra !== 32'h0) begin bad++; $display("FAIL mulh_eal got=%h exp=0", ra); end
    do_mop32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ra, rb, nb, ta, tb, ca, tmo);
    total++; if (ra !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mulhu_eal got=%h exp=fffffffe", ra); end
    do_mop32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, ra, rb, nb, ta, tb, ca, tmo);
    total++; if (ra !== 32'h8000_0000 || ta !== 1'b0)
      begin bad++; $display("FAIL div_ovf got=%h trap=%b exp=80000000 trap=0", ra, ta); end
    // DONE lasts one cycle: the ALU path is back on eal right after it
    @(negedge clk);
    total++; if (busy_a !== 1'b0 || eal_a !== 32'h7FFF_FFFF)
      begin bad++; $display("FAIL done_one_cycle busy=%b eal=%h exp busy=0 eal=7fffffff", busy_a, eal_a); end
    do_mop32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, ra, rb, nb, ta, tb, ca, tmo);
    total++; if (ra !== 32'h0 || ta !== 1'b0) begin bad++; $display("FAIL rem_ovf got=%h trap=%b exp=0 trap=0", ra, ta); end
    do_mop32(3'b101, 32'd7, 32'd0, ra, rb, nb, ta, tb, ca, tmo);
    total++; if (tmo || nb != 1) begin bad++; $display("FAIL div0_latency got=%0d exp=1", nb); end
    total++; if (ra !== 32'hFFFF_FFFF || rb !== 32'hFFFF_FFFF)
      begin bad++; $display("FAIL div0_eal got=%h/%h exp=ffffffff", ra, rb); end
    total++; if (ta !== 1'b1 || ca !== 4'd4) begin bad++; $display("FAIL div0_trap got=%b/%0d exp=1/4", ta, ca); end
    total++; if (tb !== 1'b0) begin bad++; $display("FAIL div0_notrap got=%b exp=0", tb); end
    do_mop32(3'b111, 32'd7, 32'd0, ra, rb, nb, ta, tb, ca, tmo);
    total++; if (ra !== 32'd7) begin bad++; $display("FAIL remu0_eal got=%h exp=7", ra); end
  endtask

  task automatic test_md_random();
    logic [31:0] ra, rb, a, b;
    logic [63:0] e;
    logic [2:0]  op;
    int          nb, enb;
    logic        ta, tb;
    logic [3:0]  ca;
    bit          tmo, d0;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7)); a = pick32(); b = pick32();
      e  = ref_m(32, op, {32'd0, a}, {32'd0, b});
      d0 = op[2] && (b == 0);
      enb = d0 ? 1 : 33;
      do_mop32(op, a, b, ra, rb, nb, ta, tb, ca, tmo);
      total++; if (tmo || nb != enb) begin bad++; $display("FAIL rnd_latency op=%0d got=%0d exp=%0d", op, nb, enb); end
      total++; if (ra !== e[31:0] || rb !== e[31:0])
        begin bad++; $display("FAIL rnd_eal op=%0d a=%h b=%h got=%h/%h exp=%h", op, a, b, ra, rb, e[31:0]); end
      total++; if (ta !== d0 || tb !== 1'b0) begin bad++; $display("FAIL rnd_trap op=%0d got=%b/%b exp=%b/0", op, ta, tb, d0); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] ra, rb;
    int          nb;
    logic        ta, tb;
    logic [3:0]  ca;
    bit          tmo, seen;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      f3 = 3'b100; ea = 32'd100; eb = 32'd7; ealuc = A_ADD; ex_v = 1; md_req = 1;
      @(posedge clk); #1;
      repeat (10) @(posedge clk);
      #1;
      if (k == 0) flush = 1; else clrn = 0;
      @(negedge clk);
      total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL abort_busy_run k=%0d got=%b exp=1", k, busy_a); end
      @(posedge clk); #1;
      flush = 0; clrn = 1; ex_v = 0; md_req = 0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (busy_a !== 1'b0 || trap_a !== 1'b0 || eal_a !== 32'd107) seen = 1;
      end
      total++; if (seen) begin bad++; $display("FAIL abort_idle k=%0d busy=%b eal=%h exp busy=0 eal=107", k, busy_a, eal_a); end
    end
    // flush on the DONE cycle of a divide by zero hides result and trap
    @(posedge clk); #1;
    f3 = 3'b101; ea = 32'd7; eb = 32'd0; ex_v = 1; md_req = 1;
    @(posedge clk); #1; flush = 1;
    @(negedge clk);
    total++; if (eal_a !== 32'd7 || trap_a !== 1'b0)
      begin bad++; $display("FAIL flush_done eal=%h trap=%b exp eal=7 trap=0", eal_a, trap_a); end
    // flush in IDLE blocks the start
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL flush_idle busy=%b exp=0", busy_a); end
    @(posedge clk); #1; flush = 0; ex_v = 0; md_req = 0;
    do_mop32(3'b100, 32'd100, 32'd7, ra, rb, nb, ta, tb, ca, tmo);
    total++; if (ra !== 32'd14) begin bad++; $display("FAIL div_after_abort got=%0d exp=14", ra); end
    do_mop32(3'b110, 32'hFFFF_FF9C, 32'd7, ra, rb, nb, ta, tb, ca, tmo);
    total++; if (ra !== 32'hFFFF_FFFE) begin bad++; $display("FAIL rem_neg got=%h exp=fffffffe", ra); end
  endtask

  task automatic test_xlen16();
    logic [15:0] r, a, b;
    logic [63:0] e;
    logic [2:0]  op;
    int          nb;
    bit          tmo;
    do_mop16(3'b000, 16'h0100, 16'h0100, r, nb, tmo);
    total++; if (tmo || nb != 17) begin bad++; $display("FAIL x16_latency got=%0d exp=17", nb); end
    total++; if (r !== 16'h0) begin bad++; $display("FAIL x16_mul got=%h exp=0", r); end
    for (int i = 0; i < 16; i++) begin
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      b = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      e = ref_m(16, op, {48'd0, a}, {48'd0, b});
      do_mop16(op, a, b, r, nb, tmo);
      total++; if (tmo || r !== e[15:0]) begin bad++; $display("FAIL x16_rnd op=%0d a=%h b=%h got=%h exp=%h", op, a, b, r, e[15:0]); end
    end
  endtask

  task automatic test_result_mux();
    @(posedge clk); #1;
    ex_v = 1; md_req = 0; ea = 32'd1; eb = 32'd2; ealuc = A_ADD;
    epc4 = $urandom; csrd = $urandom; ecall = 1; csr_is = 1;
    ecall16 = 1; epc16 = 16'hBEEF; exv16 = 1; ea16 = 16'd3; eb16 = 16'd4;
    @(negedge clk);
    total++; if (eal_a !== epc4) begin bad++; $display("FAIL ecall_eal got=%h exp=%h", eal_a, epc4); end
    total++; if (eal16 !== 16'hBEEF) begin bad++; $display("FAIL ecall16_eal got=%h exp=beef", eal16); end
    @(posedge clk); #1; ecall = 0; ecall16 = 0;
    @(negedge clk);
    total++; if (eal_a !== csrd) begin bad++; $display("FAIL csr_eal got=%h exp=%h", eal_a, csrd); end
    total++; if (eal16 !== 16'd7) begin bad++; $display("FAIL alu16_eal got=%h exp=7", eal16); end
    @(posedge clk); #1; csr_is = 0;
    @(negedge clk);
    total++; if (eal_a !== 32'd3) begin bad++; $display("FAIL alu_eal_mux got=%h exp=3", eal_a); end
    @(posedge clk); #1; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_md_directed();
    test_md_random();
    test_abort();
    test_xlen16();
    test_result_mux();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
